// File: rtl/bus_cmd_pkg.sv
// Shared types and constants for the byte-stream bus command initiator.
// Covers state encoding, default command bytes and response fill values.
package bus_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP,
    ACK
  } state_t;

  localparam logic [7:0]  DEF_CMD_WRITE = 8'h57;
  localparam logic [7:0]  DEF_CMD_READ  = 8'h52;
  localparam logic [7:0]  ACK_BYTE      = 8'h06;
  localparam logic [7:0]  NAK_BYTE      = 8'h15;
  localparam logic [31:0] TIMEOUT_FILL  = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_cmd_initiator_if.sv
// Byte-stream in/out handshakes plus the native valid/ready memory bus.
// master = the initiator, slave = host streams and bus responder.
interface bus_cmd_initiator_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;

  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    output valid,
    input  ready,
    output addr,
    output wdata,
    output wstrb,
    input  rdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  valid,
    output ready,
    input  addr,
    input  wdata,
    input  wstrb,
    output rdata
  );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Cycle counter bounding how long a bus request may wait for ready.
// expired is high once the count sits at TIMEOUT_CYCLES-1.
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_cmd_initiator.sv
// Turns host command bytes into single bus transactions, streams reads back.
// Optional BUS_CMD_WRITE_ACK_EN adds a one-byte ACK/NAK after each write.
module bus_cmd_initiator
  import bus_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] CMD_WRITE      = DEF_CMD_WRITE,
  parameter logic [7:0] CMD_READ       = DEF_CMD_READ
) (
  input  logic                  clk,
  input  logic                  rstn,
  bus_cmd_initiator_if.master   bus,
  output logic                  busy
);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  byte_cnt;
  logic        is_write;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp;
  logic        expired;
  logic        in_fire;
  logic        out_fire;
  logic        last_byte;
  logic        is_cmd;
`ifdef BUS_CMD_WRITE_ACK_EN
  logic        ack_nak;
`endif

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign is_cmd    = (bus.in_data == CMD_WRITE)
                  || (bus.in_data == CMD_READ);

  assign bus.in_ready = (state == IDLE)
                     || (state == ADDR)
                     || (state == DATA);
  assign bus.valid    = (state == BUS);
  assign bus.addr     = addr_q;
  assign bus.wdata    = wdata_q;
  assign bus.wstrb    = (state == BUS && is_write) ? 4'hF : 4'h0;
  assign busy         = (state != IDLE);

`ifdef BUS_CMD_WRITE_ACK_EN
  assign bus.out_valid = (state == RESP) || (state == ACK);
`else
  assign bus.out_valid = (state == RESP);
`endif

  always_comb begin
    bus.out_data = 8'h00;
    if (state == RESP) begin
      bus.out_data = resp[{byte_cnt, 3'b000} +: 8];
    end
`ifdef BUS_CMD_WRITE_ACK_EN
    if (state == ACK) begin
      bus.out_data = ack_nak ? NAK_BYTE : ACK_BYTE;
    end
`endif
  end

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state != BUS),
    .enable  (state == BUS && !bus.ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_fire && is_cmd) state_nx = ADDR;
      end
      ADDR: begin
        if (in_fire && last_byte) begin
          state_nx = is_write ? DATA : BUS;
        end
      end
      DATA: begin
        if (in_fire && last_byte) state_nx = BUS;
      end
      BUS: begin
        // ready takes priority over an expiry on the same edge
        if (bus.ready || expired) begin
`ifdef BUS_CMD_WRITE_ACK_EN
          state_nx = is_write ? ACK : RESP;
`else
          state_nx = is_write ? IDLE : RESP;
`endif
        end
      end
      RESP: begin
        if (out_fire && last_byte) state_nx = IDLE;
      end
      ACK: begin
`ifdef BUS_CMD_WRITE_ACK_EN
        if (out_fire) state_nx = IDLE;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      resp     <= '0;
      byte_cnt <= '0;
      is_write <= 1'b0;
`ifdef BUS_CMD_WRITE_ACK_EN
      ack_nak  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            byte_cnt <= '0;
            is_write <= (bus.in_data == CMD_WRITE);
          end
        end
        ADDR: begin
          if (in_fire) begin
            addr_q[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (in_fire) begin
            wdata_q[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        BUS: begin
          if (bus.ready) begin
            if (!is_write) resp <= bus.rdata;
`ifdef BUS_CMD_WRITE_ACK_EN
            ack_nak <= 1'b0;
`endif
          end else if (expired) begin
            if (!is_write) resp <= TIMEOUT_FILL;
`ifdef BUS_CMD_WRITE_ACK_EN
            ack_nak <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (out_fire) byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cmd_initiator.sv
// Randomised command bench for bus_cmd_initiator against a byte-level model.
// Responder latency per command decides success or timeout in the model.
module tb_bus_cmd_initiator;
  import bus_cmd_pkg::*;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;

  bus_cmd_initiator_if bif ();

  bus_cmd_initiator #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // responder: ready on the lat-th cycle valid is seen high
  int          lat = 2;
  logic [31:0] rd_val = '0;
  int          vcnt = 0;
  int          last_high = 0;
  int          txn_cnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  bit          unstable = 0;

  always begin
    @(negedge clk);
    if (bif.valid) begin
      vcnt++;
      if (vcnt == 1) begin
        cap_addr  = bif.addr;
        cap_wdata = bif.wdata;
        cap_wstrb = bif.wstrb;
      end else if (bif.addr !== cap_addr || bif.wdata !== cap_wdata
                   || bif.wstrb !== cap_wstrb) begin
        unstable = 1;
      end
      bif.ready = (vcnt == lat);
      bif.rdata = (vcnt == lat) ? rd_val : $urandom;
    end else begin
      if (vcnt != 0) begin
        last_high = vcnt;
        txn_cnt++;
      end
      vcnt = 0;
      bif.ready = ($urandom_range(0, 3) == 0);
      bif.rdata = $urandom;
    end
  end

  // consumer: random back-pressure, optional 5-cycle stall on byte 1
  logic [7:0] got[$];
  bit         stall_en = 0;
  int         hold = 0;
  logic [7:0] stall_byte = '0;

  always begin
    @(negedge clk);
    if (bif.out_valid) begin
      if (stall_en && got.size() == 1 && hold < 5) begin
        if (hold > 0) check("stall_hold", bif.out_data, stall_byte);
        hold++;
        bif.out_ready = 1'b0;
      end else begin
        bif.out_ready = ($urandom_range(0, 2) != 0);
        if (bif.out_ready) got.push_back(bif.out_data);
      end
    end else begin
      bif.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(logic [7:0] b);
    int w;
    w = 0;
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    while (!bif.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_wait", 32'(bif.in_ready), 1);
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  task automatic send_garbage();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == 8'h57 || b == 8'h52);
    send(b);
    check("busy_garbage", 32'(busy), 0);
  endtask

  task automatic run_cmd(bit wr, logic [31:0] a, logic [31:0] d,
                         logic [31:0] rv, int l, int garbage);
    logic [7:0]  exp[$];
    logic [31:0] rword;
    bit          ok;
    int          w;
    int          t0;
    ok = (l >= 1 && l <= T);
    lat = l;
    rd_val = rv;
    unstable = 0;
    got.delete();
    t0 = txn_cnt;
    if (!wr) begin
      rword = ok ? rv : 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) exp.push_back(rword[8*i +: 8]);
    end
`ifdef BUS_CMD_WRITE_ACK_EN
    else exp.push_back(ok ? 8'h06 : 8'h15);
`endif
    stall_byte = (exp.size() > 1) ? exp[1] : 8'h00;
    for (int g = 0; g < garbage; g++) send_garbage();
    send(wr ? 8'h57 : 8'h52);
    check("busy_cmd", 32'(busy), 1);
    for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
    w = 0;
    while ((busy || txn_cnt == t0) && w < T + 300) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("busy_end", 32'(busy), 0);
    check("txn_count", 32'(txn_cnt - t0), 1);
    check("valid_cycles", 32'(last_high), ok ? 32'(l) : 32'(T));
    check("addr", cap_addr, a);
    check("wstrb", 32'(cap_wstrb), wr ? 32'hF : 32'h0);
    if (wr) check("wdata", cap_wdata, d);
    check("bus_stable", 32'(unstable), 0);
    check("in_ready_idle", 32'(bif.in_ready), 1);
    check("resp_len", 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check("resp_byte", (i < got.size()) ? 32'(got[i]) : 32'hXX,
            32'(exp[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lsel;
    int          l;
    logic [31:0] a;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bif.valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(bif.out_valid), 0);
    check("rst_out_data", 32'(bif.out_data), 0);
    check("rst_wstrb", 32'(bif.wstrb), 0);
    check("rst_addr", bif.addr, 0);
    check("rst_wdata", bif.wdata, 0);
    check("rst_in_ready", 32'(bif.in_ready), 1);
    rstn = 1'b1;
    @(negedge clk);

    run_cmd(1, 32'h0010_0000, 32'hDEAD_BEEF, 32'h0, 2, 0);

    stall_en = 1;
    hold = 0;
    run_cmd(0, 32'h0010_0004, 32'h0, 32'h0000_0193, 2, 0);
    stall_en = 0;
    check("stall_seen", 32'(hold), 5);

    run_cmd(0, 32'h0000_0000, 32'h0, 32'h1111_2222, 0, 0);
    run_cmd(1, 32'h0000_0040, 32'h5555_AAAA, 32'h0, 0, 0);
    run_cmd(0, 32'h0000_0080, 32'h0, 32'h3333_4444, T + 1, 0);

    send(8'h00);
    check("busy_g0", 32'(busy), 0);
    send(8'hA5);
    check("busy_g1", 32'(busy), 0);
    run_cmd(0, 32'h0010_0000, 32'h0, 32'h0BAD_F00D, 3, 0);

    run_cmd(0, 32'h2000_0010, 32'h0, 32'hCAFE_F00D, T, 0);
    run_cmd(1, 32'h2000_0014, 32'h0123_4567, 32'h0, T, 0);

    lat = 0;
    send(8'h52);
    for (int i = 0; i < 4; i++) send(8'h00);
    for (int i = 0; i < 10 && !bif.valid; i++) @(negedge clk);
    check("pre_rst_valid", 32'(bif.valid), 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bif.valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bif.in_ready), 1);
    run_cmd(0, 32'h0010_0000, 32'h0, 32'h1234_5678, 2, 0);

    for (int n = 0; n < 40; n++) begin
      lsel = $urandom_range(0, 6);
      case (lsel)
        0: l = 2;
        1: l = 3;
        2: l = $urandom_range(2, T);
        3: l = T;
        4: l = T + 1;
        5: l = 0;
        default: l = $urandom_range(2, 5);
      endcase
      a = $urandom;
      run_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom, l,
              $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
